jk_exc_drv: RTL and testbench

- Excitation driver for a bank of negedge-clocked JK flip-flops; the drive-side counterpart of the team's JK flop cell.
- Accepts target states through a valid/ready interface and buffers them in a small FIFO.
- Computes per-bit J/K excitation from the flop bank's fed-back Q, then checks on the following edge that the bank reached the target.
- Sits between sequence/test controllers and JK-based counter/register datapaths.

---
 rtl/jk_pkg.sv | 23 ++
 rtl/jk_exc_drv_if.sv | 29 ++
 rtl/jk_tgt_fifo.sv | 51 +++++
 rtl/jk_exc_drv.sv | 96 +++++++++
 tb/tb_jk_exc_drv.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/jk_pkg.sv
// Shared types and the per-bit JK excitation rule for the excitation driver.
package jk_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    localparam int ERR_CNT_W = 8;

    // Returns {j, k} that moves a JK flop from q to t on its next capture edge.
    function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic toggle_pref);
        logic [1:0] jk;
        jk = 2'b00;
        if (q != t) begin
            if (toggle_pref) jk = 2'b11;
            else if (t)      jk = 2'b10;
            else             jk = 2'b01;
        end
        return jk;
    endfunction

endpackage

// File: rtl/jk_exc_drv_if.sv
// Target handshake plus flop-bank excitation/feedback bundle for jk_exc_drv.
interface jk_exc_drv_if
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic                 tgt_valid;
    logic [WIDTH-1:0]     tgt_data;
    logic                 tgt_ready;
    logic                 run;
    logic                 err_clr;
    logic [WIDTH-1:0]     q_fb;
    logic [WIDTH-1:0]     j;
    logic [WIDTH-1:0]     k;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output tgt_valid, tgt_data, run, err_clr, q_fb,
        input  tgt_ready, j, k, busy, done, err, err_count
    );

    modport slave (
        input  tgt_valid, tgt_data, run, err_clr, q_fb,
        output tgt_ready, j, k, busy, done, err, err_count
    );
endinterface

// File: rtl/jk_tgt_fifo.sv
// Small synchronous FIFO holding queued target states.
module jk_tgt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage is not reset; a flush only needs the pointers and count cleared.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/jk_exc_drv.sv
// Drives J/K for a negedge JK flop bank toward queued targets and checks the result on the next posedge.
//
//   state | meaning
//   IDLE  | j=k=0, waiting for run with a non-empty FIFO
//   APPLY | excitation presented; next posedge checks q_fb against the target
module jk_exc_drv
    import jk_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 4,
    parameter int TOGGLE_PREF = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    jk_exc_drv_if.slave   bus
);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    state_t               r_state;
    logic [WIDTH-1:0]     r_j;
    logic [WIDTH-1:0]     r_k;
    logic [WIDTH-1:0]     r_exp;
    logic                 r_done;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic [WIDTH-1:0]     w_head;
    logic [WIDTH-1:0]     w_j_nxt;
    logic [WIDTH-1:0]     w_k_nxt;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_load;
    logic                 w_mismatch;

    jk_tgt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.tgt_valid),
        .i_pop   (w_load),
        .i_data  (bus.tgt_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_load     = bus.run && !w_empty;
    assign w_mismatch = (r_state == APPLY) && (bus.q_fb != r_exp);

    always_comb begin
        w_j_nxt = '0;
        w_k_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {w_j_nxt[i], w_k_nxt[i]} = jk_excite(bus.q_fb[i], w_head[i], TOGGLE_PREF != 0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_j         <= '0;
            r_k         <= '0;
            r_exp       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err <= w_mismatch;
            if (bus.err_clr)
                r_err_count <= {{(ERR_CNT_W-1){1'b0}}, w_mismatch};
            else if (w_mismatch && r_err_count != ERR_MAX)
                r_err_count <= r_err_count + 1'b1;

            // Loading uses the q_fb just checked, so excitation chains back-to-back.
            if (w_load) begin
                r_j     <= w_j_nxt;
                r_k     <= w_k_nxt;
                r_exp   <= w_head;
                r_state <= APPLY;
                r_done  <= 1'b0;
            end else begin
                r_j     <= '0;
                r_k     <= '0;
                r_state <= IDLE;
                r_done  <= (r_state == APPLY) && w_empty;
            end
        end
    end

    assign bus.tgt_ready = !w_full;
    assign bus.j         = r_j;
    assign bus.k         = r_k;
    assign bus.busy      = (r_state == APPLY);
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.err_count = r_err_count;
endmodule

// File: tb/tb_jk_exc_drv.sv
// Bench for jk_exc_drv: JK flop bank on q_fb, queue-based reference model, table and directed sequences.
module tb_jk_exc_drv;
    localparam int W = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jk_exc_drv_if #(.WIDTH(W)) a0 ();
    jk_exc_drv_if #(.WIDTH(W)) a1 ();

    jk_exc_drv #(.WIDTH(W), .DEPTH(D), .TOGGLE_PREF(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(a0.slave));
    jk_exc_drv #(.WIDTH(W), .DEPTH(D), .TOGGLE_PREF(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(a1.slave));

    logic [W-1:0] bank0, bank1, fault0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank0 <= '0;
            bank1 <= '0;
        end else begin
            bank0 <= (a0.j & ~bank0) | (~a0.k & bank0);
            bank1 <= (a1.j & ~bank1) | (~a1.k & bank1);
        end
    end
    assign a0.q_fb = bank0 & ~fault0;
    assign a1.q_fb = bank1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of accepted targets and one in-flight expected state.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_exp, m_j, m_k;
    bit           m_busy, m_done, m_err, m_ready;
    int           m_cnt;

    task automatic model_clear();
        m_q.delete();
        m_exp = '0; m_j = '0; m_k = '0;
        m_busy = 0; m_done = 0; m_err = 0; m_ready = 1; m_cnt = 0;
    endtask

    task automatic model_eval();
        logic [W-1:0] q, t;
        bit can_push;
        q = a0.q_fb;
        can_push = m_q.size() < D;
        m_err = m_busy && (q !== m_exp);
        if (m_err) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (a0.err_clr) m_cnt = m_err ? 1 : 0;
        m_done = 0;
        if (a0.run && m_q.size() > 0) begin
            t = m_q.pop_front();
            m_j = t & ~q;
            m_k = ~t & q;
            m_exp = t;
            m_busy = 1;
        end else begin
            m_j = '0;
            m_k = '0;
            m_done = m_busy && (m_q.size() == 0);
            m_busy = 0;
        end
        if (a0.tgt_valid && can_push) m_q.push_back(a0.tgt_data);
        m_ready = m_q.size() < D;
    endtask

    task automatic step();
        @(negedge clk); #1;
        model_eval();
        @(posedge clk); #1;
        check("j", 32'(a0.j), 32'(m_j));
        check("k", 32'(a0.k), 32'(m_k));
        check("busy", 32'(a0.busy), 32'(m_busy));
        check("done", 32'(a0.done), 32'(m_done));
        check("err", 32'(a0.err), 32'(m_err));
        check("err_count", 32'(a0.err_count), 32'(m_cnt));
        check("tgt_ready", 32'(a0.tgt_ready), 32'(m_ready));
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_j", 32'(a0.j), 0);
        check("rst_k", 32'(a0.k), 0);
        check("rst_busy", 32'(a0.busy), 0);
        check("rst_ready", 32'(a0.tgt_ready), 1);
        check("rst_err_count", 32'(a0.err_count), 0);
        check("rst_done_err", 32'({a0.done, a0.err}), 0);
        a0.tgt_valid = 0; a0.run = 0; a0.err_clr = 0; fault0 = '0;
        a1.tgt_valid = 0; a1.run = 0; a1.err_clr = 0;
        model_clear();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic         valid;
        logic [W-1:0] data;
        logic         run;
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic         busy;
        logic         done;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 4'h5, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'hA, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 4'hF, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 4'h0, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 4'h0, 1'b1, 4'h0, 4'hF, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0};

        a0.tgt_valid = 0; a0.tgt_data = '0; a0.run = 0; a0.err_clr = 0; fault0 = '0;
        a1.tgt_valid = 0; a1.tgt_data = '0; a1.run = 0; a1.err_clr = 0;
        @(posedge clk); #1;
        do_reset();

        // Back-to-back table
        for (int i = 0; i < 7; i++) begin
            a0.tgt_valid = tbl[i].valid; a0.tgt_data = tbl[i].data; a0.run = tbl[i].run;
            step();
            check($sformatf("tbl%0d_j", i), 32'(a0.j), 32'(tbl[i].j));
            check($sformatf("tbl%0d_k", i), 32'(a0.k), 32'(tbl[i].k));
            check($sformatf("tbl%0d_busy", i), 32'(a0.busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_done", i), 32'(a0.done), 32'(tbl[i].done));
            check($sformatf("tbl%0d_err", i), 32'(a0.err), 0);
        end

        // Single target from q=0
        a0.tgt_valid = 1; a0.tgt_data = 4'hA; step();
        a0.tgt_valid = 0; step();
        check("single_j", 32'(a0.j), 32'h0A);
        check("single_k", 32'(a0.k), 0);
        step();
        check("single_q", 32'(a0.q_fb), 32'h0A);
        check("single_done", 32'(a0.done), 1);
        check("single_err", 32'(a0.err), 0);
        check("single_jk_idle", 32'({a0.j, a0.k}), 0);

        // Backpressure: fill with run=0, 5th offer refused, then drain in order
        a0.run = 0;
        for (int i = 0; i < 4; i++) begin
            a0.tgt_valid = 1; a0.tgt_data = 4'(3 * i + 3); step();
        end
        check("bp_full_ready", 32'(a0.tgt_ready), 0);
        a0.tgt_data = 4'hE; step();
        check("bp_5th_ready", 32'(a0.tgt_ready), 0);
        a0.tgt_valid = 0; a0.run = 1; step();
        check("bp_ready_after_pop", 32'(a0.tgt_ready), 1);
        for (int i = 0; i < 5; i++) step();
        check("bp_final_q", 32'(a0.q_fb), 32'h0C);

        // Mid-run reset discards queue and in-flight target
        a0.tgt_valid = 1; a0.tgt_data = 4'h7; step();
        a0.tgt_data = 4'h2; step();
        do_reset();
        a0.run = 1;
        for (int i = 0; i < 4; i++) step();

        // Fault on q_fb[0]: mismatch pulses, saturation, clear
        fault0 = 4'h1;
        a0.tgt_valid = 1; a0.tgt_data = 4'h1; step();
        a0.tgt_valid = 0; step();
        step();
        check("fault_err", 32'(a0.err), 1);
        check("fault_cnt1", 32'(a0.err_count), 1);
        a0.tgt_valid = 1;
        for (int i = 0; i < 300; i++) step();
        a0.tgt_valid = 0;
        for (int i = 0; i < 3; i++) step();
        check("fault_sat", 32'(a0.err_count), 255);
        fault0 = '0;
        a0.err_clr = 1; step();
        a0.err_clr = 0;
        check("err_clr", 32'(a0.err_count), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            a0.tgt_valid = 1'($urandom_range(0, 1));
            a0.tgt_data  = 4'($urandom);
            a0.run       = ($urandom_range(0, 9) < 7);
            a0.err_clr   = ($urandom_range(0, 29) == 0);
            fault0       = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            step();
        end
        a0.tgt_valid = 0; a0.run = 1; a0.err_clr = 0; fault0 = '0;
        for (int i = 0; i < 8; i++) step();

        // Toggle-preference instance
        a1.run = 1; a1.tgt_valid = 1; a1.tgt_data = 4'h3; step();
        a1.tgt_data = 4'h5; step();
        check("tog_j3", 32'(a1.j), 32'h3);
        a1.tgt_valid = 0; step();
        check("tog_j", 32'(a1.j), 32'h6);
        check("tog_k", 32'(a1.k), 32'h6);
        check("tog_err_mid", 32'(a1.err), 0);
        step();
        check("tog_q", 32'(a1.q_fb), 32'h5);
        check("tog_err", 32'(a1.err), 0);
        check("tog_done", 32'(a1.done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
